// File: rtl/line_buffer_5row_if.sv
// ---------------------------------------------------------------------------
// line_buffer_5row_if
//   Pixel-stream / column-output bundle between a raster pixel source, the
//   5-row line buffer and the downstream 5x5 window shift array.
//
//   Stream in (source -> line buffer):
//     valid_in   pixel_in valid this cycle, never back-pressured
//     sof_in     qualified by valid_in, marks pixel (row 0, col 0)
//     pixel_in   DATA_W-bit pixel
//   Column out (line buffer -> window array):
//     row_out_0..row_out_4   current line and lines t-1..t-4, same column
//     valid_out              row_out_* valid
//     win_valid              window array holds a full in-image 5x5 window
//     frame_done             one-cycle pulse with the last pixel of a frame
//
//   Modports: slave = line buffer side, master = pixel source / bench side.
// ---------------------------------------------------------------------------
interface line_buffer_5row_if #(
  parameter int DATA_W = 8
);
  logic              valid_in;
  logic              sof_in;
  logic [DATA_W-1:0] pixel_in;

  logic [DATA_W-1:0] row_out_0;
  logic [DATA_W-1:0] row_out_1;
  logic [DATA_W-1:0] row_out_2;
  logic [DATA_W-1:0] row_out_3;
  logic [DATA_W-1:0] row_out_4;
  logic              valid_out;
  logic              win_valid;
  logic              frame_done;

  modport slave (
    input  valid_in,
    input  sof_in,
    input  pixel_in,
    output row_out_0,
    output row_out_1,
    output row_out_2,
    output row_out_3,
    output row_out_4,
    output valid_out,
    output win_valid,
    output frame_done
  );

  modport master (
    output valid_in,
    output sof_in,
    output pixel_in,
    input  row_out_0,
    input  row_out_1,
    input  row_out_2,
    input  row_out_3,
    input  row_out_4,
    input  valid_out,
    input  win_valid,
    input  frame_done
  );
endinterface

// File: rtl/line_buffer_5row.sv
// ---------------------------------------------------------------------------
// line_buffer_5row
//   Producer side of the 5x5 sliding-window path. Takes a raster-order pixel
//   stream (one pixel per valid cycle), keeps the previous K-1 = 4 image lines
//   in a shift chain of line memories, and presents the current pixel together
//   with the pixels of the four lines above it in the same column. Lines not
//   yet written in the current frame are zero-filled.
//
//   Ports:
//     clk          rising-edge clock
//     rst_n        asynchronous active-low reset (counters and outputs)
//     lb_if.slave  pixel stream in / five-row column out, see
//                  line_buffer_5row_if for the signal list
//     out_col      (LB_POS_OUT_EN only) column of the pixel on row_out_*
//     out_row      (LB_POS_OUT_EN only) row of the pixel on row_out_*
//
//   Optional feature: define LB_POS_OUT_EN to add the out_col / out_row
//   position ports. Without it the ports are absent and all other behaviour
//   is unchanged.
//
//   Only K = 5 is meaningful: the column output has exactly five row ports.
// ---------------------------------------------------------------------------
module line_buffer_5row #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = 8,
  parameter int K      = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  line_buffer_5row_if.slave        lb_if
`ifdef LB_POS_OUT_EN
  ,
  output logic [$clog2(IMG_W)-1:0] out_col,
  output logic [$clog2(IMG_H)-1:0] out_row
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int NL = K - 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_ARM  = CW'(K - 1);
  localparam logic [RW-1:0] ROW_ARM  = RW'(K - 1);

  typedef logic [DATA_W-1:0] pix_t;

  // Line k of the frame above the current one is valid only once the current
  // row index has reached k; earlier rows read stale data from the previous
  // frame (or uninitialised memory) and are forced to zero.
  function automatic pix_t line_or_zero(input logic [RW-1:0] r,
                                        input logic [RW-1:0] k,
                                        input pix_t          d);
    return (r >= k) ? d : '0;
  endfunction

  // Raster position counters
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // Effective position of the pixel on pixel_in (sof_in forces (0,0))
  logic [CW-1:0] c_cur;
  logic [RW-1:0] r_cur;
  logic          accept;
  logic          last_col;
  logic          last_row;

  // Line memories: lbuf_q[0] holds line t-1, lbuf_q[NL-1] holds line t-NL
  pix_t lbuf_q [NL][IMG_W];
  pix_t ld     [NL];

  // Registered column output and control
  pix_t rows_q [K];
  pix_t rows_d [K];
  logic valid_q;
  logic win_arm_q, win_arm_d;
  logic frame_done_q, frame_done_d;
  logic win_valid_q;

  always_comb begin
    accept   = lb_if.valid_in;
    c_cur    = lb_if.sof_in ? '0 : col_q;
    r_cur    = lb_if.sof_in ? '0 : row_q;
    last_col = (c_cur == COL_LAST);
    last_row = (r_cur == ROW_LAST);

    for (int k = 0; k < NL; k++) begin
      ld[k] = lbuf_q[k][c_cur];
    end

    rows_d[0] = lb_if.pixel_in;
    for (int k = 1; k < K; k++) begin
      rows_d[k] = line_or_zero(r_cur, RW'(k), ld[k-1]);
    end

    win_arm_d    = (r_cur >= ROW_ARM) && (c_cur >= COL_ARM);
    frame_done_d = last_col && last_row;

    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (!last_col) begin
        col_d = c_cur + CW'(1);
        row_d = r_cur;
      end else begin
        col_d = '0;
        row_d = last_row ? '0 : (r_cur + RW'(1));
      end
    end
  end

  // ---- stage boundary: pixel accepted -> column output (latency 1) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      valid_q      <= 1'b0;
      win_arm_q    <= 1'b0;
      frame_done_q <= 1'b0;
      win_valid_q  <= 1'b0;
      for (int k = 0; k < K; k++) begin
        rows_q[k] <= '0;
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      valid_q      <= accept;
      frame_done_q <= accept && frame_done_d;
      // ---- stage boundary: column output -> window array contents ----
      win_valid_q  <= valid_q && win_arm_q;
      if (accept) begin
        win_arm_q <= win_arm_d;
        for (int k = 0; k < K; k++) begin
          rows_q[k] <= rows_d[k];
        end
      end
    end
  end

  // Shift chain: same column read before write, so each line moves down
  // one slot as the new pixel enters slot 0. No reset; masked by r_cur.
  always_ff @(posedge clk) begin
    if (accept) begin
      lbuf_q[0][c_cur] <= lb_if.pixel_in;
      for (int k = 1; k < NL; k++) begin
        lbuf_q[k][c_cur] <= ld[k-1];
      end
    end
  end

  assign lb_if.row_out_0  = rows_q[0];
  assign lb_if.row_out_1  = rows_q[1];
  assign lb_if.row_out_2  = rows_q[2];
  assign lb_if.row_out_3  = rows_q[3];
  assign lb_if.row_out_4  = rows_q[4];
  assign lb_if.valid_out  = valid_q;
  assign lb_if.win_valid  = win_valid_q;
  assign lb_if.frame_done = frame_done_q;

`ifdef LB_POS_OUT_EN
  logic [CW-1:0] pos_col_q;
  logic [RW-1:0] pos_row_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_col_q <= '0;
      pos_row_q <= '0;
    end else if (accept) begin
      pos_col_q <= c_cur;
      pos_row_q <= r_cur;
    end
  end

  assign out_col = pos_col_q;
  assign out_row = pos_row_q;
`endif

endmodule

// File: tb/tb_line_buffer_5row.sv
module tb_line_buffer_5row;

  localparam int IMG_W  = 28;
  localparam int IMG_H  = 28;
  localparam int DATA_W = 8;
  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);

  logic clk;
  logic rst_n;

  line_buffer_5row_if #(.DATA_W(DATA_W)) lb_if ();

`ifdef LB_POS_OUT_EN
  logic [CW-1:0] out_col;
  logic [RW-1:0] out_row;
`endif

  line_buffer_5row #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .DATA_W(DATA_W),
    .K     (5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .lb_if(lb_if)
`ifdef LB_POS_OUT_EN
    ,
    .out_col(out_col),
    .out_row(out_row)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] rows;   // {r4,r3,r2,r1,r0}
    bit          fd;
    bit          arm;
    int          r;
    int          c;
  } exp_t;

  exp_t        sb_q[$];
  logic [39:0] last_rows = '0;
  int          last_r = 0;
  int          last_c = 0;
  bit          prev_arm = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          win_cnt = 0;
  int          fd_cnt = 0;

  // Reference model position and frame value offset
  int          mr = 0;
  int          mc = 0;
  int          mbase = 0;
  bit          hand_en = 1'b0;
  logic [39:0] hand_v = '0;

  function automatic logic [7:0] pix(input int r, input int c, input int b);
    int v;
    v = r * IMG_W + c + b;
    return v[7:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic mon_step();
    logic [39:0] got;
    exp_t        e;
    got = {lb_if.row_out_4, lb_if.row_out_3, lb_if.row_out_2,
           lb_if.row_out_1, lb_if.row_out_0};
    if (!rst_n) begin
      last_rows = '0;
      last_r    = 0;
      last_c    = 0;
      prev_arm  = 1'b0;
      return;
    end
    chk("win_valid", 64'(lb_if.win_valid), 64'(prev_arm));
    if (lb_if.win_valid) win_cnt++;
    if (lb_if.frame_done) fd_cnt++;
    if (lb_if.valid_out) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output got=%h exp=none", got);
        prev_arm = 1'b0;
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("rows(%0d,%0d)", e.r, e.c), 64'(got), 64'(e.rows));
        chk($sformatf("frame_done(%0d,%0d)", e.r, e.c), 64'(lb_if.frame_done), 64'(e.fd));
`ifdef LB_POS_OUT_EN
        chk("pos", 64'({out_row, out_col}), 64'({RW'(e.r), CW'(e.c)}));
`endif
        last_rows = e.rows;
        last_r    = e.r;
        last_c    = e.c;
        prev_arm  = e.arm;
      end
    end else begin
      chk("hold_rows", 64'(got), 64'(last_rows));
      chk("idle_frame_done", 64'(lb_if.frame_done), 64'(0));
`ifdef LB_POS_OUT_EN
      chk("hold_pos", 64'({out_row, out_col}), 64'({RW'(last_r), CW'(last_c)}));
`endif
      prev_arm = 1'b0;
    end
  endtask

  task automatic send(input bit sof, input int nbase);
    exp_t        e;
    logic [7:0]  v;
    if (sof) begin
      mr    = 0;
      mc    = 0;
      mbase = nbase;
    end
    for (int k = 0; k < 5; k++) begin
      v = (mr >= k) ? pix(mr - k, mc, mbase) : 8'h00;
      e.rows[k*8 +: 8] = v;
    end
    if (hand_en) e.rows = hand_v;
    hand_en = 1'b0;
    e.fd  = (mr == IMG_H - 1) && (mc == IMG_W - 1);
    e.arm = (mr >= 4) && (mc >= 4);
    e.r   = mr;
    e.c   = mc;
    sb_q.push_back(e);
    lb_if.valid_in = 1'b1;
    lb_if.sof_in   = sof;
    lb_if.pixel_in = pix(mr, mc, mbase);
    if (mc < IMG_W - 1) begin
      mc++;
    end else begin
      mc = 0;
      mr = (mr < IMG_H - 1) ? mr + 1 : 0;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    lb_if.valid_in = 1'b0;
    lb_if.sof_in   = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    repeat (4) idle();
    chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rows"}, 64'({lb_if.row_out_4, lb_if.row_out_3, lb_if.row_out_2,
                             lb_if.row_out_1, lb_if.row_out_0}), 64'(0));
    chk({tag, "_valid_out"}, 64'(lb_if.valid_out), 64'(0));
    chk({tag, "_win_valid"}, 64'(lb_if.win_valid), 64'(0));
    chk({tag, "_frame_done"}, 64'(lb_if.frame_done), 64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wb;
    int fb;
    rst_n          = 1'b1;
    lb_if.valid_in = 1'b0;
    lb_if.sof_in   = 1'b0;
    lb_if.pixel_in = '0;
    #1 rst_n = 1'b0;
    #2 chk_outputs_zero("reset");

    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Frame A (continuous, sof at natural position) then frame B back-to-back
    // with random idle gaps.
    wb = win_cnt;
    fb = fd_cnt;
    for (int i = 0; i < IMG_W * IMG_H; i++) begin
      if (mr == 4 && mc == 7)   begin hand_en = 1'b1; hand_v = 40'h07233F5B77; end
      if (mr == 2 && mc == 5)   begin hand_en = 1'b1; hand_v = 40'h000005213D; end
      if (mr == 27 && mc == 27) begin hand_en = 1'b1; hand_v = 40'h9FBBD7F30F; end
      send(i == 0, 0);
    end
    for (int i = 0; i < IMG_W * IMG_H; i++) begin
      if (i > 0 && $urandom_range(0, 99) < 40) idle();
      send(i == 0, 0);
    end
    drain();
    chk("win_count_AB", 64'(win_cnt - wb), 64'(1152));
    chk("frame_done_count_AB", 64'(fd_cnt - fb), 64'(2));

    // Frame C: restart with sof at old pixel (10,3), new frame offset 0xAA
    wb = win_cnt;
    fb = fd_cnt;
    for (int i = 0; i < 10 * IMG_W + 3; i++) send(i == 0, 0);
    hand_en = 1'b1;
    hand_v  = 40'h00000000AA;
    send(1'b1, 8'hAA);
    for (int i = 1; i < IMG_W * IMG_H; i++) send(1'b0, 0);
    drain();
    chk("win_count_C", 64'(win_cnt - wb), 64'(720));
    chk("frame_done_count_C", 64'(fd_cnt - fb), 64'(1));

    // Frame D: async reset mid-line after pixel (6,12)
    wb = win_cnt;
    fb = fd_cnt;
    for (int i = 0; i < 6 * IMG_W + 13; i++) send(i == 0, 8'h55);
    idle();
    #7 rst_n = 1'b0;
    #1 chk_outputs_zero("async_reset");
    @(negedge clk);
    sb_q.delete();
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("win_count_D", 64'(win_cnt - wb), 64'(57));
    chk("frame_done_count_D", 64'(fd_cnt - fb), 64'(0));

    // Frame E: first pixel after reset is (0,0) without sof
    wb    = win_cnt;
    fb    = fd_cnt;
    mr    = 0;
    mc    = 0;
    mbase = 8'h33;
    hand_en = 1'b1;
    hand_v  = 40'h0000000033;
    for (int i = 0; i < IMG_W * IMG_H; i++) send(1'b0, 0);
    drain();
    chk("win_count_E", 64'(win_cnt - wb), 64'(576));
    chk("frame_done_count_E", 64'(fd_cnt - fb), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_buffer_5row.md
Name: line_buffer_5row

Overview:
- Producer side of the 5x5 sliding-window interface for the conv stages.
- Accepts a raster-order pixel stream, one pixel per valid cycle, and stores the last K-1 image lines.
- Drives K vertically aligned pixels of the current column in parallel: current line plus lines t-1..t-4.
- Downstream, the 5x5 window shift array consumes these outputs; line_buffer_5row also flags when that array holds a complete valid window.

Parameters:
- IMG_W, 28, pixels per line (column counter wraps at IMG_W-1).
- IMG_H, 28, lines per frame (row counter wraps at IMG_H-1).
- DATA_W, 8, pixel width.
- K, 5, window height; K-1 = 4 line memories. Only K=5 is supported, matching the fixed 5 row ports.

Ports:
- clk, in, 1, system clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- valid_in, in, 1, pixel_in valid this cycle; always accepted, no backpressure.
- sof_in, in, 1, qualified by valid_in; marks this pixel as (row 0, col 0).
- pixel_in, in, DATA_W, input pixel.
- row_out_0, out, DATA_W, current line pixel (t).
- row_out_1, out, DATA_W, line t-1, same column.
- row_out_2, out, DATA_W, line t-2, same column.
- row_out_3, out, DATA_W, line t-3, same column.
- row_out_4, out, DATA_W, line t-4, same column.
- valid_out, out, 1, row_out_* valid; drive straight into the window array's valid_in.
- win_valid, out, 1, the window array's 25 registers hold a full in-image 5x5 window this cycle.
- frame_done, out, 1, single-cycle pulse aligned with valid_out of the last pixel (IMG_H-1, IMG_W-1).

Behaviour:
- Reset (rst_n low, async): col=0, row=0. All row_out_*=0, valid_out=0, win_valid=0, frame_done=0. Line memory contents are don't-care; masked by the row rules below.

Accepted pixel at position (r,c), where (r,c)=(0,0) if sof_in=1, else (row,col):
- Read: ld_k = lbuf[k-1][c] for k=1..4.
- Memory update on the same edge (shift chain, read-before-write at the same address):
  - lbuf[0][c] <= pixel_in
  - lbuf[k][c] <= lbuf[k-1][c] for k=1..3
- Outputs, registered, valid on the next cycle (latency 1):
  - row_out_0 = pixel_in
  - row_out_k = (r >= k) ? ld_k : 0. This zero-fills lines not yet written in this frame.
- valid_out = 1 for exactly one cycle.
- win_arm = (r >= K-1) && (c >= K-1), registered alongside valid_out.
- Counter advance:
  - c < IMG_W-1: col <= c+1, row <= r.
  - Otherwise col <= 0.
  - If also r < IMG_H-1: row <= r+1.
  - Otherwise row <= 0 and frame_done = 1 with valid_out.

No pixel (valid_in=0):
- valid_out=0 and frame_done=0 next cycle. row_out_* hold their values.
- Counters and memories hold.

win_valid:
- Registered as valid_out && win_arm, so it asserts one cycle after valid_out, aligned with the window array's registers.
- Deasserts the next cycle.
- IMG_W=28, IMG_H=28 gives exactly (28-4)*(28-4) = 576 win_valid pulses per frame.

Boundary and timing cases:
- Line wrap: the window array keeps the previous line's last 4 columns. win_valid masks this via c >= K-1; no flush is needed.
- sof_in mid-frame: counters restart at (0,0), and the old frame's lines are zero-masked through r. No frame_done is generated for the aborted frame.
- sof_in at natural position (0,0): no effect beyond normal operation.
- Back-to-back frames: no idle cycle needed; frame_done and the next frame's first pixel may be adjacent.
- rst_n mid-frame: as reset; the next pixel is (0,0).
- Gaps in valid_in between any pixels: no effect on results.

Optional Feature:
- Macro LB_POS_OUT_EN.
- Defined: adds ports out_col (clog2(IMG_W) bits) and out_row (clog2(IMG_H) bits).
  - Both are registered (r,c) of the pixel currently on row_out_*, valid with valid_out, reset 0.
  - They hold when valid_out=0. Used for debug and pooling alignment.
- Undefined: ports absent; all other behaviour identical.

Test Plan:
- Reset then one 28x28 frame, pixel = (r*28+c) & 0xFF, continuous valid:
  - At pixel (4,7): row_out_0..4 = 0x77, 0x5B, 0x3F, 0x23, 0x07.
  - frame_done exactly once, with pixel 783 (0x0F).
- Same frame, count win_valid:
  - Exactly 576 pulses.
  - First pulse 2 cycles after pixel (4,4) is accepted.
  - None for any c < 4 or r < 4.
- Rows 0-3 zero-fill: at pixel (2,5) (0x3D), row_out_1 = 0x21, row_out_2 = 0x05, row_out_3 = 0, row_out_4 = 0.
- Random valid_in gaps (about 40% idle) over a full frame:
  - row_out_* sequence and win_valid count (576) identical to the continuous run.
  - Outputs hold during gaps.
- sof_in asserted at old pixel (10,3) with a new frame value 0xAA:
  - Next output row_out_0 = 0xAA, row_out_1..4 = 0.
  - No frame_done until 784 pixels after the restart.
- rst_n pulsed low asynchronously mid-line at pixel (6,12):
  - All outputs 0 immediately.
  - Next pixel treated as (0,0); row_out_1..4 = 0.
